// File: rtl/mlblock_cfg_pkg.sv
// Shared definitions for the ML-block configuration loader.
//   state_t        : loader FSM states
//   cfg_chain_len  : total serial chain length for a given block geometry
package mlblock_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Chain length = input/data half + result/control bits + per-MAC bits for every MAC.
    function automatic int cfg_chain_len(input int i_d_half,
                                         input int res_d_cntl,
                                         input int per_mac_bits,
                                         input int mac_units);
        return i_d_half + res_d_cntl + per_mac_bits * mac_units;
    endfunction

endpackage

// File: rtl/mlblock_config_loader_if.sv
// Word-level side of the config loader.
//   cfg_valid/cfg_data/cfg_ready : word handshake (accepted when both high)
//   abort                        : cancel a load in progress
//   done                         : one-cycle completion pulse
//   rb_data/rb_valid             : previous chain contents captured by the last completed load
interface mlblock_config_loader_if #(
    parameter int CHAIN_LEN = 32
);
    logic                 cfg_valid;
    logic [CHAIN_LEN-1:0] cfg_data;
    logic                 cfg_ready;
    logic                 abort;
    logic                 done;
    logic [CHAIN_LEN-1:0] rb_data;
    logic                 rb_valid;

    modport master (
        output cfg_valid, cfg_data, abort,
        input  cfg_ready, done, rb_data, rb_valid
    );

    modport slave (
        input  cfg_valid, cfg_data, abort,
        output cfg_ready, done, rb_data, rb_valid
    );
endinterface

// File: rtl/mlblock_config_loader.sv
// Serial configuration chain loader.
// Accepts a CHAIN_LEN-bit word, shifts it MSB first into an external shift
// chain while capturing the bits falling out of the chain tail, then pulses
// done and presents the captured old chain contents on rb_data.
//   clk, reset : clock, asynchronous active-high reset
//   cfg        : word handshake / status (mlblock_config_loader_if.slave)
//   config_en  : chain shift enable (registered)
//   config_in  : serial data into chain head (registered)
//   config_out : serial data from chain tail
module mlblock_config_loader
    import mlblock_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    mlblock_config_loader_if.slave  cfg,
    output logic                    config_en,
    output logic                    config_in,
    input  logic                    config_out
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] tx_q, tx_d;
    logic [CHAIN_LEN-1:0] rb_data_q, rb_data_d;
    logic                 config_en_q, config_en_d;
    logic                 config_in_q, config_in_d;
    logic                 done_q, done_d;
    logic                 rb_valid_q, rb_valid_d;

    // Timeline after the accept edge (cycle 0 = first SHIFT cycle):
    //   cycle 0          : outputs being loaded, config_en still 0
    //   cycles 1..N      : config_en=1, chain shifts on each closing edge
    //   cycle N+1        : DONE, done=1
    // cnt_q counts completed shifts, so it equals N-1 during the last
    // enabled cycle and the edge closing that cycle is the terminal one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rb_data_d   = rb_data_q;
        config_en_d = config_en_q;
        config_in_d = config_in_q;
        done_d      = 1'b0;
        rb_valid_d  = rb_valid_q;

        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    tx_d       = cfg.cfg_data;
                    cnt_d      = '0;
                    rb_valid_d = 1'b0;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                if (cfg.abort) begin
                    // Abort wins over terminal count; chain is left as-is.
                    config_en_d = 1'b0;
                    config_in_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    if (config_en_q) begin
                        // Tail bit seen on the same edge that shifts the chain.
                        rb_data_d = {rb_data_q[CHAIN_LEN-2:0], config_out};
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                    if (config_en_q && (cnt_q == LAST_CNT)) begin
                        config_en_d = 1'b0;
                        config_in_d = 1'b0;
                        done_d      = 1'b1;
                        rb_valid_d  = 1'b1;
                        state_d     = DONE;
                    end else begin
                        config_en_d = 1'b1;
                        config_in_d = tx_q[CHAIN_LEN-1];
                        tx_d        = {tx_q[CHAIN_LEN-2:0], 1'b0};
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                config_en_d = 1'b0;
                config_in_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_q        <= '0;
            rb_data_q   <= '0;
            config_en_q <= 1'b0;
            config_in_q <= 1'b0;
            done_q      <= 1'b0;
            rb_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rb_data_q   <= rb_data_d;
            config_en_q <= config_en_d;
            config_in_q <= config_in_d;
            done_q      <= done_d;
            rb_valid_q  <= rb_valid_d;
        end
    end

    assign config_en     = config_en_q;
    assign config_in     = config_in_q;
    assign cfg.cfg_ready = (state_q == IDLE);
    assign cfg.done      = done_q;
    assign cfg.rb_data   = rb_data_q;
    assign cfg.rb_valid  = rb_valid_q;

endmodule

// File: tb/tb_mlblock_config_loader.sv
// Directed bench for mlblock_config_loader with an 8-bit shift-chain model.
module tb_mlblock_config_loader;
    localparam int CL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          config_en, config_in, config_out;
    logic [CL-1:0] chain;
    logic [CL-1:0] pre_val;
    logic          pre_ld;

    int total = 0;
    int bad   = 0;

    mlblock_config_loader_if #(.CHAIN_LEN(CL)) cif ();

    mlblock_config_loader #(.CHAIN_LEN(CL)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg        (cif),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out)
    );

    always #5 clk = ~clk;

    // External chain: position 0 fed by config_in, position CL-1 drives config_out.
    assign config_out = chain[CL-1];
    always @(posedge clk) begin
        if (pre_ld)         chain <= pre_val;
        else if (config_en) chain <= {chain[CL-2:0], config_in};
    end

    typedef struct {
        logic [CL-1:0] pre;
        logic [CL-1:0] data;
        logic [CL-1:0] exp_seq;
        logic [CL-1:0] exp_rb;
        logic [CL-1:0] exp_chain;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [CL-1:0] v);
        pre_val = v;
        pre_ld  = 1'b1;
        @(negedge clk);
        pre_ld  = 1'b0;
    endtask

    // Called at a negedge while idle. Offers 'data', then watches cycles
    // 0..CL+1 after the accept edge, sampling each at its negedge.
    // Bit k of the masks is the signal level during cycle k.
    task automatic do_load(input logic [CL-1:0] data, input int abort_at,
                           input logic hold2, input logic [CL-1:0] data2,
                           output logic [CL-1:0] seq, output logic [15:0] en_m,
                           output logic [15:0] rdy_m, output logic [15:0] done_m);
        seq = '0; en_m = '0; rdy_m = '0; done_m = '0;
        cif.cfg_valid = 1'b1;
        cif.cfg_data  = data;
        @(posedge clk);
        for (int k = 0; k < CL + 2; k++) begin
            @(negedge clk);
            en_m[k]   = config_en;
            rdy_m[k]  = cif.cfg_ready;
            done_m[k] = cif.done;
            if (config_en) seq = {seq[CL-2:0], config_in};
            if (hold2) begin
                cif.cfg_valid = 1'b1;
                cif.cfg_data  = data2;
            end else begin
                cif.cfg_valid = 1'b0;
            end
            cif.abort = (k == abort_at);
        end
        cif.abort = 1'b0;
    endtask

    logic [CL-1:0] seq;
    logic [15:0]   en_m, rdy_m, done_m;

    initial begin
        vecs[0] = '{pre: 8'h00, data: 8'hA5, exp_seq: 8'hA5, exp_rb: 8'h00, exp_chain: 8'hA5};
        vecs[1] = '{pre: 8'h3C, data: 8'hFF, exp_seq: 8'hFF, exp_rb: 8'h3C, exp_chain: 8'hFF};
        vecs[2] = '{pre: 8'h81, data: 8'h0F, exp_seq: 8'h0F, exp_rb: 8'h81, exp_chain: 8'h0F};
        vecs[3] = '{pre: 8'h5A, data: 8'hC3, exp_seq: 8'hC3, exp_rb: 8'h5A, exp_chain: 8'hC3};

        cif.cfg_valid = 1'b0;
        cif.cfg_data  = '0;
        cif.abort     = 1'b0;
        pre_val       = '0;
        pre_ld        = 1'b1;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        pre_ld = 1'b0;
        @(negedge clk);
        chk("rst_ready",    32'(cif.cfg_ready), 32'd1);
        chk("rst_en",       32'(config_en),     32'd0);
        chk("rst_in",       32'(config_in),     32'd0);
        chk("rst_done",     32'(cif.done),      32'd0);
        chk("rst_rb_valid", 32'(cif.rb_valid),  32'd0);
        chk("rst_rb_data",  32'(cif.rb_data),   32'd0);

        // Full loads: CL enabled cycles (1..CL), done in cycle CL+1, i.e. high
        // in the cycle closed by edge accept+CL+2; never ready while busy.
        for (int i = 0; i < 4; i++) begin
            preload(vecs[i].pre);
            do_load(vecs[i].data, -1, 1'b0, '0, seq, en_m, rdy_m, done_m);
            chk($sformatf("v%0d_seq", i),  32'(seq),    32'(vecs[i].exp_seq));
            chk($sformatf("v%0d_en", i),   32'(en_m),   32'h01FE);
            chk($sformatf("v%0d_done", i), 32'(done_m), 32'h0200);
            chk($sformatf("v%0d_rdy", i),  32'(rdy_m),  32'h0000);
            @(negedge clk);
            chk($sformatf("v%0d_rb", i),    32'(cif.rb_data),  32'(vecs[i].exp_rb));
            chk($sformatf("v%0d_rbv", i),   32'(cif.rb_valid), 32'd1);
            chk($sformatf("v%0d_chain", i), 32'(chain),        32'(vecs[i].exp_chain));
            chk($sformatf("v%0d_ready", i), 32'(cif.cfg_ready), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_rb_hold", i), 32'(cif.rb_data), 32'(vecs[i].exp_rb));
        end

        // Abort during the 4th shift cycle: enable drops next cycle, no done.
        preload(8'h00);
        do_load(8'hA5, 4, 1'b0, '0, seq, en_m, rdy_m, done_m);
        chk("abort_en",    32'(en_m),   32'h001E);
        chk("abort_done",  32'(done_m), 32'h0000);
        chk("abort_rdy",   32'(rdy_m),  32'h03E0);
        chk("abort_seq",   32'(seq),    32'h0A);
        chk("abort_chain", 32'(chain),  32'h0A);
        chk("abort_rbv",   32'(cif.rb_valid), 32'd0);

        // Abort on the final shift cycle: beats terminal count.
        @(negedge clk);
        preload(8'h00);
        do_load(8'h3C, CL, 1'b0, '0, seq, en_m, rdy_m, done_m);
        chk("abort_last_en",   32'(en_m),   32'h01FE);
        chk("abort_last_done", 32'(done_m), 32'h0000);
        chk("abort_last_rdy",  32'(rdy_m),  32'h0200);
        chk("abort_last_rbv",  32'(cif.rb_valid), 32'd0);

        // Second word held on cfg_valid through the whole load is ignored
        // until the loader is back in IDLE.
        @(negedge clk);
        preload(8'h00);
        do_load(8'hA5, -1, 1'b1, 8'h3C, seq, en_m, rdy_m, done_m);
        chk("hold_seq",  32'(seq),    32'hA5);
        chk("hold_rdy",  32'(rdy_m),  32'h0000);
        chk("hold_done", 32'(done_m), 32'h0200);
        @(negedge clk);
        chk("hold_idle_ready", 32'(cif.cfg_ready), 32'd1);
        chk("hold_chain1",     32'(chain),         32'hA5);
        do_load(8'h3C, -1, 1'b0, '0, seq, en_m, rdy_m, done_m);
        chk("hold2_seq",  32'(seq),    32'h3C);
        chk("hold2_done", 32'(done_m), 32'h0200);
        @(negedge clk);
        chk("hold2_rb",    32'(cif.rb_data), 32'hA5);
        chk("hold2_chain", 32'(chain),       32'h3C);

        // Reset in the 3rd shift cycle: enable must fall without a clock edge.
        @(negedge clk);
        cif.cfg_valid = 1'b1;
        cif.cfg_data  = 8'h96;
        @(posedge clk);
        @(negedge clk);
        cif.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_pre_en", 32'(config_en), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_en",    32'(config_en),     32'd0);
        chk("rst_mid_in",    32'(config_in),     32'd0);
        chk("rst_mid_done",  32'(cif.done),      32'd0);
        chk("rst_mid_rbv",   32'(cif.rb_valid),  32'd0);
        chk("rst_mid_rb",    32'(cif.rb_data),   32'd0);
        chk("rst_mid_ready", 32'(cif.cfg_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", 32'(cif.cfg_ready), 32'd1);
        chk("rst_rel_en",    32'(config_en),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mlblock_config_loader.md
MLBLOCK_CONFIG_LOADER -- requirements
Module: mlblock_config_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 32, total bit length of the serial config chain being driven (>=2).
REQ-002 SHALL have localparam CNT_W, derived as $clog2(CHAIN_LEN+1), the width of the shift counter.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-005 SHALL have port cfg_valid, input, 1 bit, a new config word is offered.
REQ-006 SHALL have port cfg_data, input, CHAIN_LEN bits; bit k is the final value for chain position k (0 = first register after config_in).
REQ-007 SHALL have port cfg_ready, output, 1 bit; the loader accepts a word when cfg_valid is also high.
REQ-008 SHALL have port abort, input, 1 bit, terminates a load in progress.
REQ-009 SHALL have port config_en, output, 1 bit, shift enable to the chain.
REQ-010 SHALL have port config_in, output, 1 bit, serial data to the chain head.
REQ-011 SHALL have port config_out, input, 1 bit, serial data returning from the chain tail.
REQ-012 SHALL have port done, output, 1 bit, one-cycle pulse when a load completes.
REQ-013 SHALL have port rb_data, output, CHAIN_LEN bits, the previous chain contents captured during the last completed load.
REQ-014 SHALL have port rb_valid, output, 1 bit, high while rb_data holds a completed capture.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 SHALL drive cfg_ready=1 only in IDLE, and 0 in every other state.
REQ-017 SHALL, in IDLE with cfg_valid=1, register cfg_data into a shift register, clear the counter and rb_valid, and enter SHIFT on the next edge.
REQ-018 SHALL, in SHIFT, hold config_en=1 for exactly CHAIN_LEN consecutive cycles with no gaps.
REQ-019 SHALL drive config_in on shift n (n=0..CHAIN_LEN-1) as cfg_data[CHAIN_LEN-1-n], sending the MSB first.
REQ-020 SHALL drive config_en and config_in directly from registers, with no combinational path from any input.
REQ-021 SHALL, on each SHIFT cycle, sample config_out at the same edge that shifts the chain and store it in rb_data[CHAIN_LEN-1-n], so that rb_data holds the old chain contents in the cfg_data bit order.
REQ-022 SHALL move SHIFT->DONE after the cycle in which the counter reaches CHAIN_LEN-1.
REQ-023 SHALL, in DONE, drive done=1 and config_en=0 and set rb_valid=1 for exactly one cycle, then return to IDLE.
REQ-024 SHALL give a latency of CHAIN_LEN+2 cycles from the accept edge to the done pulse, with back-to-back loads separated by at least one IDLE cycle.
REQ-025 SHALL ignore cfg_valid outside IDLE, without latching cfg_data.
REQ-026 SHALL, on abort=1 in SHIFT, deassert config_en at the next edge and go to IDLE with no done pulse and rb_valid left at 0; the chain is left partially loaded.
REQ-027 SHALL give abort priority over counter terminal count in the same cycle.
REQ-028 SHALL have abort no effect in IDLE or DONE.
REQ-029 SHALL hold rb_data until the next accept.

Reset
REQ-030 SHALL, on reset, asynchronously force state=IDLE, config_en=0, config_in=0, done=0, rb_valid=0, rb_data=0, counter=0, shift register=0.
REQ-031 SHALL, when reset is asserted mid-SHIFT, drop config_en immediately without waiting for clk.
REQ-032 SHALL drive cfg_ready=1 in the first cycle after reset release.

Structure
REQ-033 SHALL place the state enum and the chain-length helper function (computing I_D_HALF + RES_D_CNTL + per-MAC bits * MAC_UNITS) in shared package mlblock_cfg_pkg.
REQ-034 SHALL be implemented as a single module with no sub-modules; the FSM, counter, TX shift register and RX capture register are all inline.

Verification
REQ-035 SHALL cover a basic load: CHAIN_LEN=8, cfg_data=8'hA5 into an 8-bit shift-register chain model -> config_in sequence 1,0,1,0,0,1,0,1; model holds 8'hA5; done at accept+10.
REQ-036 SHALL cover readback: preload the model with 8'h3C, then load 8'hFF -> rb_data=8'h3C, rb_valid=1 after done, and the model holds 8'hFF.
REQ-037 SHALL cover abort: abort at the 4th shift cycle -> config_en low on the next cycle, no done, rb_valid=0, cfg_ready=1 on the following cycle.
REQ-038 SHALL cover reset mid-op: reset asserted at the 3rd shift cycle -> config_en=0 before the next clk edge, all outputs at reset values.
REQ-039 SHALL cover an ignored request: cfg_valid held high with different data throughout SHIFT -> only the first word is shifted, and the second is accepted only after return to IDLE.
REQ-040 SHALL cover abort coinciding with the last shift: abort on the final SHIFT cycle -> no done pulse, rb_valid=0.
